slv_guard_rst_ctrl: RTL and testbench
=====================================

Name: slv_guard_rst_ctrl

Overview:
Downstream consumer of the slave guard's reset request. It converts the guard's level `rst_req` into a timed, active-low reset pulse to the guarded subordinate. It then waits for the subordinate to signal it is ready again and returns the reset-status handshake that clears the guard's request. It also keeps reset-event statistics and a sticky recovery-timeout flag for the register file.

Parameters:
- HoldCycles, 16: cycles `sub_rst_no` is held low; must be ≥1.
- RecoverTimeout, 64: maximum cycles to wait for `sub_ready_i` after reset release; must be ≥1.
- EvtCntWidth, 8: width of the saturating reset-event counter.
- HoldCntWidth, $clog2(max(HoldCycles,RecoverTimeout))+1: internal timer width (derived).

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  reset, synchronous, active-low.
- rst_req_i  in  1  reset request from the guard (OR of write and read requests); level.
- rst_stat_o  out  1  reset-status to the guard's reset-clear input.
- sub_rst_no  out  1  active-low reset to the subordinate.
- sub_ready_i  in  1  subordinate ready after reset (level).
- busy_o  out  1  high whenever FSM is not IDLE.
- evt_cnt_o  out  EvtCntWidth  number of completed reset sequences, saturating.
- timeout_o  out  1  sticky: recovery timed out at least once.
- clr_i  in  1  clears evt_cnt_o and timeout_o (register write strobe).

Behaviour:
- Single clock domain. All state updates on the rising edge of clk_i.
- rst_ni=0 sampled at an edge: FSM=IDLE, timer=0, evt_cnt_o=0, timeout_o=0, rst_stat_o=0, sub_rst_no=1, busy_o=0.
- Reset asserted mid-sequence aborts it. sub_rst_no returns to 1 on the next edge and no event is counted.
- States and transitions:
  - IDLE: sub_rst_no=1, rst_stat_o=0. When rst_req_i=1, go to ASSERT and load timer=HoldCycles-1.
  - ASSERT: sub_rst_no=0. Timer decrements each cycle. At timer==0, go to RECOVER and load timer=RecoverTimeout-1. Subordinate reset is therefore low for exactly HoldCycles cycles. rst_req_i is ignored in this state.
  - RECOVER: sub_rst_no=1.
    - If sub_ready_i=1, go to ACK.
    - Else if timer==0, set timeout_o=1 and go to ACK anyway, so the guard is never left locked.
    - Else the timer decrements.
    - If sub_ready_i=1 and timer==0 occur in the same cycle, ready wins and timeout_o is not set.
  - ACK: rst_stat_o=1, sub_rst_no=1. Stay until rst_req_i=0, then go to IDLE and increment evt_cnt_o (saturating at all-ones).
- Minimum latency from rst_req_i rising to rst_stat_o rising: 1 (IDLE→ASSERT) + HoldCycles + 1 (RECOVER with ready already high) cycles.
- rst_stat_o is registered (state-decoded from the state register, no combinational path from inputs).
- A new rst_req_i is only accepted in IDLE. If rst_req_i rises again in the cycle IDLE is re-entered, ASSERT starts on the next edge; back-to-back sequences are legal.
- clr_i:
  - Clears evt_cnt_o and timeout_o on the next edge.
  - If it coincides with an increment, the counter becomes 0.
  - If it coincides with a timeout-set, timeout_o becomes 1 (set wins).
- busy_o = (state != IDLE).
- Glitch-free outputs: sub_rst_no is driven directly from a flop.

Decomposition:
- Add to the shared guard package:
  - State enum `rst_ctrl_state_e` with values IDLE, ASSERT, RECOVER, ACK, 2-bit encoding.
  - Type `evt_cnt_t`, used by the register package so hw2reg fields match the counter width.
- No sub-module needed. The timer and saturating counter are inline; a generic down-counter from the common cells library may be used for the timer.

Test Plan:
- Basic sequence: HoldCycles=16, sub_ready_i tied 1, pulse rst_req_i high and drop it when rst_stat_o=1 -> sub_rst_no low exactly 16 cycles starting 1 cycle after the request; rst_stat_o high 18 cycles after request; evt_cnt_o=1; timeout_o=0.
- Recovery timeout: sub_ready_i held 0, RecoverTimeout=64 -> rst_stat_o rises 64 cycles after sub_rst_no releases; timeout_o=1; evt_cnt_o increments once rst_req_i drops.
- Ready at timeout boundary: sub_ready_i rises in the same cycle the timer hits 0 -> ACK entered, timeout_o remains 0.
- Held request: rst_req_i stays high 100 cycles past rst_stat_o -> FSM stays in ACK, no second pulse on sub_rst_no, evt_cnt_o unchanged until rst_req_i drops, then +1.
- Saturation and clear: EvtCntWidth=2, run 5 sequences -> evt_cnt_o=3; assert clr_i in the cycle of the 6th increment -> evt_cnt_o=0.
- Reset mid-sequence: rst_ni=0 during ASSERT (cycle 5 of 16) -> next edge sub_rst_no=1, state IDLE, evt_cnt_o unchanged (0), rst_stat_o=0.

Source files
------------

// File: rtl/slv_guard_rst_ctrl_pkg.sv
// Shared slave-guard types: reset controller state and event counter.
// Imported by the reset controller and by the register package.
package slv_guard_rst_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ASSERT  = 2'd1,
    RECOVER = 2'd2,
    ACK     = 2'd3
  } rst_ctrl_state_e;

  localparam int unsigned EvtCntW = 8;

  typedef logic [EvtCntW-1:0] evt_cnt_t;

  function automatic int unsigned max_u(
    input int unsigned a,
    input int unsigned b
  );
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/slv_guard_rst_ctrl.sv
// Turns the guard's level reset request into a timed subordinate reset,
// waits for recovery, acknowledges the guard and keeps reset statistics.
module slv_guard_rst_ctrl
  import slv_guard_rst_ctrl_pkg::*;
#(
  parameter int unsigned HoldCycles     = 16,
  parameter int unsigned RecoverTimeout = 64,
  parameter int unsigned EvtCntWidth    = $bits(evt_cnt_t)
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   rst_req_i,
  output logic                   rst_stat_o,
  output logic                   sub_rst_no,
  input  logic                   sub_ready_i,
  output logic                   busy_o,
  output logic [EvtCntWidth-1:0] evt_cnt_o,
  output logic                   timeout_o,
  input  logic                   clr_i
);

  localparam int unsigned HoldCntWidth =
    $clog2(max_u(HoldCycles, RecoverTimeout)) + 1;

  localparam logic [HoldCntWidth-1:0] HoldLd =
    HoldCntWidth'(HoldCycles - 1);
  localparam logic [HoldCntWidth-1:0] RecLd =
    HoldCntWidth'(RecoverTimeout - 1);

  rst_ctrl_state_e         r_state;
  logic [HoldCntWidth-1:0] r_timer;
  logic                    r_sub_rst_n;
  logic                    r_rst_stat;
  logic                    r_timeout;
  logic [EvtCntWidth-1:0]  r_evt;

  logic w_tmr_zero;
  logic w_evt_inc;
  logic w_evt_sat;
  logic w_to_set;

  assign w_tmr_zero = (r_timer == '0);
  assign w_evt_sat  = &r_evt;
  assign w_evt_inc  = (r_state == ACK) && !rst_req_i;
  assign w_to_set   = (r_state == RECOVER) && !sub_ready_i
                      && w_tmr_zero;

  // Outputs are updated together with the state so they come from flops.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_state     <= IDLE;
      r_timer     <= '0;
      r_sub_rst_n <= 1'b1;
      r_rst_stat  <= 1'b0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (rst_req_i) begin
            r_state     <= ASSERT;
            r_timer     <= HoldLd;
            r_sub_rst_n <= 1'b0;
          end
        end
        ASSERT: begin
          if (w_tmr_zero) begin
            r_state     <= RECOVER;
            r_timer     <= RecLd;
            r_sub_rst_n <= 1'b1;
          end else begin
            r_timer <= r_timer - HoldCntWidth'(1);
          end
        end
        RECOVER: begin
          if (sub_ready_i || w_tmr_zero) begin
            r_state    <= ACK;
            r_rst_stat <= 1'b1;
          end else begin
            r_timer <= r_timer - HoldCntWidth'(1);
          end
        end
        ACK: begin
          if (!rst_req_i) begin
            r_state    <= IDLE;
            r_rst_stat <= 1'b0;
          end
        end
        default: begin
          r_state     <= IDLE;
          r_sub_rst_n <= 1'b1;
          r_rst_stat  <= 1'b0;
        end
      endcase
    end
  end

  // Clear beats increment; a timeout set beats clear.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_evt     <= '0;
      r_timeout <= 1'b0;
    end else begin
      if (clr_i) begin
        r_evt <= '0;
      end else if (w_evt_inc && !w_evt_sat) begin
        r_evt <= r_evt + EvtCntWidth'(1);
      end
      if (w_to_set) begin
        r_timeout <= 1'b1;
      end else if (clr_i) begin
        r_timeout <= 1'b0;
      end
    end
  end

  assign sub_rst_no = r_sub_rst_n;
  assign rst_stat_o = r_rst_stat;
  assign busy_o     = (r_state != IDLE);
  assign evt_cnt_o  = r_evt;
  assign timeout_o  = r_timeout;

endmodule

// File: tb/tb_slv_guard_rst_ctrl.sv
// Randomized scoreboard bench for the slave guard reset controller.
// Stimulus plans each sequence and queues its expected timeline.
module tb_slv_guard_rst_ctrl;

  localparam int HOLD = 16;
  localparam int REC  = 64;
  localparam int EVTW = 2;
  localparam int EMAX = (1 << EVTW) - 1;

  logic            clk;
  logic            rst_n;
  logic            rst_req;
  logic            rst_stat;
  logic            sub_rst_n;
  logic            sub_ready;
  logic            busy;
  logic [EVTW-1:0] evt_cnt;
  logic            timeout;
  logic            clr;

  slv_guard_rst_ctrl #(
    .HoldCycles    (HOLD),
    .RecoverTimeout(REC),
    .EvtCntWidth   (EVTW)
  ) dut (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .rst_req_i  (rst_req),
    .rst_stat_o (rst_stat),
    .sub_rst_no (sub_rst_n),
    .sub_ready_i(sub_ready),
    .busy_o     (busy),
    .evt_cnt_o  (evt_cnt),
    .timeout_o  (timeout),
    .clr_i      (clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int low_start;
    int ack_cyc;
    int exp_to;
    int drop_cyc;
    int exp_evt;
  } exp_t;

  exp_t q[$];
  exp_t cur;

  int  n_tests = 0;
  int  n_fail  = 0;
  int  n_seq   = 0;
  int  n_done  = 0;
  int  m_evt   = 0;
  int  m_to    = 0;
  bit  mon_en  = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cyc %0d)",
               nm, act, exp, cyc);
    end
  endtask

  task automatic wait_until(input int n);
    while (cyc < n) @(negedge clk);
  endtask

  // Ready rises in recovery cycle d; d >= REC means it never does.
  task automatic run_seq(input int d, input int h, input int g,
                         input bit clr_ack, input bit clr_drop);
    int   c, m, a;
    bit   to;
    exp_t e;
    c  = cyc;
    to = (d >= REC);
    m  = to ? REC - 1 : d;
    a  = c + 2 + HOLD + m;
    if (clr_ack) m_evt = 0;
    if (to) m_to = 1;
    else if (clr_ack) m_to = 0;
    e.low_start = c + 1;
    e.ack_cyc   = a;
    e.exp_to    = m_to;
    e.drop_cyc  = a + h + 1;
    if (clr_drop) begin
      m_evt = 0;
      m_to  = 0;
    end else begin
      m_evt = (m_evt == EMAX) ? EMAX : m_evt + 1;
    end
    e.exp_evt = m_evt;
    q.push_back(e);
    n_seq++;
    rst_req   = 1'b1;
    sub_ready = 1'b0;
    if (!to) begin
      wait_until(c + 1 + HOLD + d);
      sub_ready = 1'b1;
    end
    if (clr_ack) begin
      wait_until(a - 1);
      clr = 1'b1;
      wait_until(a);
      clr = 1'b0;
    end
    wait_until(a + h);
    rst_req   = 1'b0;
    sub_ready = 1'b0;
    clr       = clr_drop;
    wait_until(a + h + 1);
    clr = 1'b0;
    wait_until(a + h + 1 + g);
  endtask

  // Monitor: reacts to output edges and compares with queued timelines.
  bit prev_sub  = 1'b1;
  bit prev_stat = 1'b0;
  int fall_cyc  = 0;
  int rise_cyc  = 0;

  initial begin
    forever begin
      @(negedge clk);
      if (mon_en) begin
        if (prev_sub && !sub_rst_n) begin
          if (q.size() == 0) chk("spurious_pulse", 1, 0);
          else chk("low_start", cyc, q[0].low_start);
          fall_cyc = cyc;
        end
        if (!prev_sub && sub_rst_n) rise_cyc = cyc;
        if (!prev_stat && rst_stat) begin
          if (q.size() == 0) begin
            chk("spurious_ack", 1, 0);
          end else begin
            cur = q.pop_front();
            chk("ack_cycle", cyc, cur.ack_cyc);
            chk("low_len", rise_cyc - fall_cyc, HOLD);
            chk("timeout_at_ack", int'(timeout), cur.exp_to);
            chk("busy_in_ack", int'(busy), 1);
          end
        end
        if (prev_stat && !rst_stat) begin
          n_done++;
          chk("ack_drop_cycle", cyc, cur.drop_cyc);
          chk("evt_cnt", int'(evt_cnt), cur.exp_evt);
          chk("busy_idle", int'(busy), 0);
        end
      end
      prev_sub  = sub_rst_n;
      prev_stat = rst_stat;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int c;
    int budget;
    rst_n     = 1'b0;
    rst_req   = 1'b1;
    sub_ready = 1'b0;
    clr       = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_sub_rst_n", int'(sub_rst_n), 1);
    chk("rst_stat", int'(rst_stat), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_evt", int'(evt_cnt), 0);
    chk("rst_timeout", int'(timeout), 0);
    rst_req = 1'b0;
    rst_n   = 1'b1;
    @(negedge clk);
    mon_en = 1'b1;
    @(negedge clk);

    run_seq(0, 0, 2, 0, 0);
    run_seq(REC + 10, 1, 0, 0, 0);
    run_seq(REC - 1, 0, 1, 0, 0);
    run_seq(3, 100, 0, 0, 0);
    run_seq(5, 2, 0, 0, 0);
    run_seq(1, 1, 1, 0, 1);
    run_seq(REC, 2, 1, 1, 0);
    for (int i = 0; i < 10; i++) begin
      run_seq($urandom_range(0, REC + 2), $urandom_range(0, 5),
              $urandom_range(0, 3), ($urandom_range(0, 3) == 0),
              ($urandom_range(0, 3) == 0));
    end

    budget = 200;
    while (q.size() != 0 && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    chk("queue_drained", q.size(), 0);
    repeat (3) @(negedge clk);
    chk("seq_done", n_done, n_seq);

    mon_en = 1'b0;
    c = cyc;
    rst_req = 1'b1;
    wait_until(c + 5);
    chk("mid_low", int'(sub_rst_n), 0);
    rst_n   = 1'b0;
    rst_req = 1'b0;
    wait_until(c + 6);
    chk("mid_sub_rst_n", int'(sub_rst_n), 1);
    chk("mid_busy", int'(busy), 0);
    chk("mid_stat", int'(rst_stat), 0);
    chk("mid_evt", int'(evt_cnt), 0);
    rst_n = 1'b1;
    repeat (HOLD + 4) @(negedge clk);
    chk("post_sub_rst_n", int'(sub_rst_n), 1);
    chk("post_evt", int'(evt_cnt), 0);
    chk("post_busy", int'(busy), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
